blockram_port_arbiter: RTL and testbench

- Shares one dual_port_blockram between NUM_REQUESTERS clients, e.g. cache lookup and refill/writeback engines.
- Runs independent round-robin arbitration on the blockram read port and write port.
- Returns read data and evicted data to the winning requester, tagged with its requester id.
- Resolves same-address read/write collisions by stalling the read, or by forwarding when compiled in.

---
 rtl/blockram_port_arbiter_pkg.sv | 28 ++
 rtl/blockram_port_arbiter_rr_arbiter.sv | 49 ++++
 rtl/blockram_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_blockram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// blockram_port_arbiter_pkg
//   Shared defaults for the blockram port arbiter and its round-robin arbiter:
//   element width, set count, set pointer width, requester count and id width,
//   the request-kind encoding, and the round-robin pointer wrap helper.
//   Optional feature macro used by the top: BLOCKRAM_ARBITER_WRITE_FORWARD_EN
//   (forward same-cycle write data to a colliding read instead of stalling it).
// -----------------------------------------------------------------------------
package blockram_port_arbiter_pkg;

    localparam int DEF_ELEMENT_W      = 64;
    localparam int DEF_NUMBER_SETS    = 64;
    localparam int DEF_SET_PTR_W      = 6;
    localparam int DEF_NUM_REQUESTERS = 2;
    localparam int DEF_REQ_ID_W       = 1;

    // Meaning of a requester's is_write bit.
    typedef enum logic {
        PORT_READ  = 1'b0,
        PORT_WRITE = 1'b1
    } port_kind_e;

    // Round-robin successor of a granted index: id+1, wrapping n-1 to 0.
    function automatic int rr_next(input int id, input int n);
        return (id >= n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/blockram_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first requesting index at or
//   after the current pointer (modulo N) and reports the pointer value to load
//   when that grant is taken. The pointer register lives in the parent.
//   Ports:
//     req       in   N     request vector
//     ptr       in   ID_W  current round-robin pointer
//     grant     out  N     one-hot grant (all zero when nothing requests)
//     grant_id  out  ID_W  encoded index of the grant
//     grant_vld out  1     a grant was made
//     ptr_next  out  ID_W  granted index + 1, wrapping N-1 to 0
// -----------------------------------------------------------------------------
module rr_arbiter
    import blockram_port_arbiter_pkg::*;
#(
    parameter int N    = DEF_NUM_REQUESTERS,
    parameter int ID_W = DEF_REQ_ID_W
)(
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_vld,
    output logic [ID_W-1:0] ptr_next
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        ptr_next  = ptr;
        idx       = '0;
        for (int off = 0; off < N; off++) begin
            idx = ID_W'((int'(ptr) + off) % N);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
                ptr_next  = ID_W'(rr_next(int'(idx), N));
            end
        end
        if (grant_vld) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/blockram_port_arbiter.sv
// -----------------------------------------------------------------------------
// blockram_port_arbiter
//   Shares one dual-port blockram between NUM_REQUESTERS clients. The read and
//   write ports are arbitrated independently, round-robin. Grants drive the
//   blockram combinationally; the response (read data, or evicted data for a
//   write) comes back one cycle later tagged with the requester id.
//   A read to the address being written in the same cycle is held back one
//   cycle so it observes the new data, unless BLOCKRAM_ARBITER_WRITE_FORWARD_EN
//   is defined, in which case it is granted and the write data is forwarded.
//   Ports:
//     clk_in, reset_in                 clock, synchronous active-high reset
//     req_valid_in/is_write_in         per-requester request and kind
//     req_addr_in/req_data_in          flattened per-requester address/data
//     req_ack_out                      combinational grant, accepting cycle
//     read_resp_valid/id/data_out      read response, one cycle after grant
//     write_resp_valid/id_out          write response, one cycle after grant
//     evict_data_out                   previous contents of the written set
//     read_en/read_set_addr_out        blockram read port
//     read_element_in                  blockram read data
//     write_en/write_set_addr/write_element_out   blockram write port
//     evict_element_in                 blockram evicted data
// -----------------------------------------------------------------------------
module blockram_port_arbiter
    import blockram_port_arbiter_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEF_ELEMENT_W,
    parameter int NUMBER_SETS                 = DEF_NUMBER_SETS,
    parameter int SET_PTR_WIDTH_IN_BITS       = DEF_SET_PTR_W,
    parameter int NUM_REQUESTERS              = DEF_NUM_REQUESTERS,
    parameter int REQ_ID_WIDTH                = DEF_REQ_ID_W
)(
    input  logic                                              clk_in,
    input  logic                                              reset_in,
    input  logic [NUM_REQUESTERS-1:0]                         req_valid_in,
    input  logic [NUM_REQUESTERS-1:0]                         req_is_write_in,
    input  logic [NUM_REQUESTERS*SET_PTR_WIDTH_IN_BITS-1:0]   req_addr_in,
    input  logic [NUM_REQUESTERS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data_in,
    output logic [NUM_REQUESTERS-1:0]                         req_ack_out,
    output logic                                              read_resp_valid_out,
    output logic [REQ_ID_WIDTH-1:0]                           read_resp_id_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            read_resp_data_out,
    output logic                                              write_resp_valid_out,
    output logic [REQ_ID_WIDTH-1:0]                           write_resp_id_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            evict_data_out,
    output logic                                              read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]                  read_set_addr_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            read_element_in,
    output logic                                              write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]                  write_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            evict_element_in
);

    localparam int DW = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam int N  = NUM_REQUESTERS;
    localparam int IW = REQ_ID_WIDTH;

    generate
        if ((1 << IW) < N) begin : g_bad_id_w
            $error("REQ_ID_WIDTH cannot encode NUM_REQUESTERS");
        end
        if ((1 << AW) < NUMBER_SETS) begin : g_bad_ptr_w
            $error("SET_PTR_WIDTH_IN_BITS cannot address NUMBER_SETS");
        end
    endgenerate

    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] data_a [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign addr_a[g] = req_addr_in[g*AW +: AW];
        assign data_a[g] = req_data_in[g*DW +: DW];
    end

    logic [N-1:0]  rd_cand, wr_cand, rd_arb_req;
    logic [N-1:0]  rd_grant, wr_grant;
    logic [IW-1:0] rd_id, wr_id;
    logic [IW-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic          rd_grant_vld, wr_grant_vld;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    // Candidates are suppressed during reset so no ack or port enable escapes.
    always_comb begin
        rd_cand = '0;
        wr_cand = '0;
        for (int i = 0; i < N; i++) begin
            rd_cand[i] = req_valid_in[i] && !reset_in &&
                         (port_kind_e'(req_is_write_in[i]) == PORT_READ);
            wr_cand[i] = req_valid_in[i] && !reset_in &&
                         (port_kind_e'(req_is_write_in[i]) == PORT_WRITE);
        end
    end

    rr_arbiter #(.N(N), .ID_W(IW)) u_wr_arb (
        .req       (wr_cand),
        .ptr       (wr_ptr),
        .grant     (wr_grant),
        .grant_id  (wr_id),
        .grant_vld (wr_grant_vld),
        .ptr_next  (wr_ptr_next)
    );

    assign wr_addr = addr_a[wr_id];
    assign wr_data = data_a[wr_id];

`ifdef BLOCKRAM_ARBITER_WRITE_FORWARD_EN
    assign rd_arb_req = rd_cand;
`else
    // Reads aimed at the set being written this cycle sit out one round so
    // they see the new contents; other reads may still win the port.
    logic [N-1:0] rd_coll;

    always_comb begin
        rd_coll = '0;
        for (int i = 0; i < N; i++) begin
            rd_coll[i] = wr_grant_vld && (addr_a[i] == wr_addr);
        end
    end

    assign rd_arb_req = rd_cand & ~rd_coll;
`endif

    rr_arbiter #(.N(N), .ID_W(IW)) u_rd_arb (
        .req       (rd_arb_req),
        .ptr       (rd_ptr),
        .grant     (rd_grant),
        .grant_id  (rd_id),
        .grant_vld (rd_grant_vld),
        .ptr_next  (rd_ptr_next)
    );

    assign rd_addr = addr_a[rd_id];

    assign req_ack_out        = rd_grant | wr_grant;
    assign read_en_out        = rd_grant_vld;
    assign read_set_addr_out  = rd_grant_vld ? rd_addr : '0;
    assign write_en_out       = wr_grant_vld;
    assign write_set_addr_out = wr_grant_vld ? wr_addr : '0;
    assign write_element_out  = wr_grant_vld ? wr_data : '0;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_grant_vld) rd_ptr <= rd_ptr_next;
            if (wr_grant_vld) wr_ptr <= wr_ptr_next;
        end
    end

    // ---- stage p1: blockram data returns, responses tagged with owner ----
    logic          rd_vld_p1, wr_vld_p1;
    logic [IW-1:0] rd_id_p1, wr_id_p1;
    logic [DW-1:0] rd_data_p1;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rd_vld_p1 <= 1'b0;
            wr_vld_p1 <= 1'b0;
            rd_id_p1  <= '0;
            wr_id_p1  <= '0;
        end else begin
            rd_vld_p1 <= rd_grant_vld;
            wr_vld_p1 <= wr_grant_vld;
            rd_id_p1  <= rd_id;
            wr_id_p1  <= wr_id;
        end
    end

`ifdef BLOCKRAM_ARBITER_WRITE_FORWARD_EN
    // The blockram returns pre-write contents on a same-set read/write, so
    // the write data is captured and substituted for the read result.
    logic          fwd_vld_p1;
    logic [DW-1:0] fwd_data_p1;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            fwd_vld_p1 <= 1'b0;
        end else begin
            fwd_vld_p1 <= rd_grant_vld && wr_grant_vld && (rd_addr == wr_addr);
        end
    end

    always_ff @(posedge clk_in) begin
        fwd_data_p1 <= wr_data;
    end

    assign rd_data_p1 = fwd_vld_p1 ? fwd_data_p1 : read_element_in;
`else
    assign rd_data_p1 = read_element_in;
`endif

    // Responses in flight are squashed as soon as reset is seen.
    assign read_resp_valid_out  = rd_vld_p1 && !reset_in;
    assign read_resp_id_out     = read_resp_valid_out ? rd_id_p1 : '0;
    assign read_resp_data_out   = read_resp_valid_out ? rd_data_p1 : '0;
    assign write_resp_valid_out = wr_vld_p1 && !reset_in;
    assign write_resp_id_out    = write_resp_valid_out ? wr_id_p1 : '0;
    assign evict_data_out       = write_resp_valid_out ? evict_element_in : '0;

endmodule

// File: tb/tb_blockram_port_arbiter.sv
module tb_blockram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 64;
`ifdef BLOCKRAM_ARBITER_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          rv   [N];
    logic          rw   [N];
    logic [AW-1:0] ra   [N];
    logic [DW-1:0] rdat [N];

    logic [N-1:0]    req_valid, req_is_write, ack;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            rresp_vld, wresp_vld, ren, wen;
    logic [0:0]      rresp_id, wresp_id;
    logic [DW-1:0]   rresp_data, evict_data, wel;
    logic [AW-1:0]   raddr, waddr;
    logic [DW-1:0]   rd_elem, ev_elem;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_valid[g]          = rv[g];
        assign req_is_write[g]       = rw[g];
        assign req_addr[g*AW +: AW]  = ra[g];
        assign req_data[g*DW +: DW]  = rdat[g];
    end

    blockram_port_arbiter dut (
        .clk_in               (clk),
        .reset_in             (rst),
        .req_valid_in         (req_valid),
        .req_is_write_in      (req_is_write),
        .req_addr_in          (req_addr),
        .req_data_in          (req_data),
        .req_ack_out          (ack),
        .read_resp_valid_out  (rresp_vld),
        .read_resp_id_out     (rresp_id),
        .read_resp_data_out   (rresp_data),
        .write_resp_valid_out (wresp_vld),
        .write_resp_id_out    (wresp_id),
        .evict_data_out       (evict_data),
        .read_en_out          (ren),
        .read_set_addr_out    (raddr),
        .read_element_in      (rd_elem),
        .write_en_out         (wen),
        .write_set_addr_out   (waddr),
        .write_element_out    (wel),
        .evict_element_in     (ev_elem)
    );

    // Blockram environment: one-cycle read, read-before-write on collisions.
    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 64'hA5A5_0000_0000_0000 | 64'(i);
            ref_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
    end

    always @(posedge clk) begin
        if (ren) rd_elem <= mem[raddr];
        if (wen) begin
            ev_elem     <= mem[waddr];
            mem[waddr]  <= wel;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration and memory semantics stated directly.
    int          m_rp = 0, m_wp = 0;
    bit          e_rv = 0, e_wv = 0;
    int          e_rid, e_wid;
    logic [63:0] e_rdata, e_ev;

    always @(negedge clk) begin : model
        int wg, rg, k;
        logic [N-1:0] eack;
        if (rst) begin
            chk("reset_quiet", 64'(|{ack, rresp_vld, wresp_vld, ren, wen, rresp_id, wresp_id,
                                     rresp_data, evict_data, raddr, waddr, wel}), 64'd0);
            m_rp = 0; m_wp = 0; e_rv = 0; e_wv = 0;
        end else begin
            chk("rd_resp_vld", 64'(rresp_vld), 64'(e_rv));
            if (e_rv) begin
                chk("rd_resp_id", 64'(rresp_id), 64'(e_rid));
                chk("rd_resp_data", rresp_data, e_rdata);
            end
            chk("wr_resp_vld", 64'(wresp_vld), 64'(e_wv));
            if (e_wv) begin
                chk("wr_resp_id", 64'(wresp_id), 64'(e_wid));
                chk("evict_data", evict_data, e_ev);
            end
            wg = -1;
            for (int off = 0; off < N; off++) begin
                k = (m_wp + off) % N;
                if (wg < 0 && rv[k] && rw[k]) wg = k;
            end
            rg = -1;
            for (int off = 0; off < N; off++) begin
                k = (m_rp + off) % N;
                if (rg < 0 && rv[k] && !rw[k] && (FWD || wg < 0 || ra[k] != ra[wg])) rg = k;
            end
            eack = '0;
            if (rg >= 0) eack[rg] = 1'b1;
            if (wg >= 0) eack[wg] = 1'b1;
            chk("ack", 64'(ack), 64'(eack));
            chk("read_en", 64'(ren), 64'(rg >= 0));
            chk("write_en", 64'(wen), 64'(wg >= 0));
            if (rg >= 0) chk("read_addr", 64'(raddr), 64'(ra[rg]));
            if (wg >= 0) begin
                chk("write_addr", 64'(waddr), 64'(ra[wg]));
                chk("write_data", wel, rdat[wg]);
            end
            e_rv = (rg >= 0);
            e_wv = (wg >= 0);
            if (rg >= 0) begin
                e_rid   = rg;
                e_rdata = (wg >= 0 && ra[rg] == ra[wg]) ? rdat[wg] : ref_mem[ra[rg]];
                m_rp    = (rg + 1) % N;
            end
            if (wg >= 0) begin
                e_wid           = wg;
                e_ev            = ref_mem[ra[wg]];
                ref_mem[ra[wg]] = rdat[wg];
                m_wp            = (wg + 1) % N;
            end
        end
    end

    // Present a request (call just after a rising edge), hold until ack.
    // Returns just after the edge that closes the accepting cycle.
    task automatic req(input int i, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int t);
        bit got = 1'b0;
        rv[i] = 1'b1; rw[i] = we; ra[i] = a; rdat[i] = d;
        t = -1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ack[i]) begin
                got = 1'b1;
                t   = cyc;
            end
            @(posedge clk); #1;
        end
        rv[i] = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL req_timeout: requester %0d got no ack, required one within 40 cycles", i);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    int ta, tb;
    int t0 [4];
    int t1 [4];

    initial begin
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rdat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back addr 63.
        req(0, 1'b1, 6'd63, 64'hFFFFFFFF00000000, ta);
        @(negedge clk);
        chk("t1_wr_resp", 64'({wresp_vld, wresp_id}), 64'b10);
        @(posedge clk); #1;
        req(0, 1'b0, 6'd63, '0, ta);
        @(negedge clk);
        chk("t1_rd_resp_vld_id", 64'({rresp_vld, rresp_id}), 64'b10);
        chk("t1_rd_data", rresp_data, 64'hFFFFFFFF00000000);
        @(posedge clk); #1;

        // Both requesters read back to back; read pointer is 1 after the last read.
        fork
            for (int k = 0; k < 4; k++) req(0, 1'b0, 6'd10, '0, t0[k]);
            for (int k = 0; k < 4; k++) req(1, 1'b0, 6'd11, '0, t1[k]);
        join
        chk("t2_req1_first", 64'(t0[0] - t1[0]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("t2_alt_req0", 64'(t0[k+1] - t0[k]), 64'd2);
            chk("t2_alt_req1", 64'(t1[k+1] - t1[k]), 64'd2);
        end
        @(posedge clk); #1;

        // Two writes to addr 61: second evicts the first.
        req(0, 1'b1, 6'd61, 64'h00000000FFFFFFFF, ta);
        req(0, 1'b1, 6'd61, 64'hFFFFFFFF00000000, ta);
        @(negedge clk);
        chk("t3_evict", evict_data, 64'h00000000FFFFFFFF);
        @(posedge clk); #1;

        // Same-cycle write and read of addr 60.
        fork
            req(0, 1'b1, 6'd60, 64'h1234, ta);
            req(1, 1'b0, 6'd60, '0, tb);
        join
        chk("t4_read_ack_delay", 64'(tb - ta), FWD ? 64'd0 : 64'd1);
        @(negedge clk);
        chk("t4_rd_resp_vld_id", 64'({rresp_vld, rresp_id}), 64'b11);
        chk("t4_rd_data", rresp_data, 64'h1234);
        @(posedge clk); #1;

        // Reset right after a read grant.
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 6'd3;
        @(negedge clk);
        chk("t5_pre_grant", 64'(ack), 64'b01);
        @(posedge clk); #1;
        rst = 1'b1;
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 6'd4;
        @(negedge clk);
        chk("t5_resp_dropped", 64'({rresp_vld, ack}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_first_grant", 64'(ack), 64'b01);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        @(negedge clk);
        chk("t5_second_grant", 64'(ack), 64'b10);
        @(posedge clk); #1;
        rv[1] = 1'b0;
        @(posedge clk); #1;

        // Independent read and write granted together.
        fork
            req(0, 1'b1, 6'd5, 64'hDEAD, ta);
            req(1, 1'b0, 6'd9, '0, tb);
        join
        chk("t6_same_cycle", 64'(tb), 64'(ta));
        @(negedge clk);
        chk("t6_both_resp", 64'({rresp_vld, wresp_vld, rresp_id, wresp_id}), 64'b1110);
        chk("t6_rd_data", rresp_data, 64'hA5A5000000000009);
        chk("t6_evict", evict_data, 64'hA5A5000000000005);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
